mux_scan_ctrl: RTL and testbench

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_ctrl_pkg.sv | 14 +
 rtl/mux_bit_sel.sv | 15 +
 rtl/mux_scan_ctrl.sv | 122 ++++++++++++
 tb/tb_mux_scan_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mux_ctrl_pkg.sv
// Shared definitions for the mux scan controller: default widths and the
// scan FSM state encoding.
package mux_ctrl_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int SELW_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mux_bit_sel.sv
// Single-bit selector: picks data[select] out of the captured word.
module mux_bit_sel
  import mux_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SELW  = SELW_DEF
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SELW-1:0]  select,
  output logic             out
);

  assign out = data[select];

endmodule

// File: rtl/mux_scan_ctrl.sv
// Serialises a captured word one bit per accepted transfer, starting at a
// chosen index and wrapping, with valid/ready handshake, abort and done pulse.
module mux_scan_ctrl
  import mux_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SELW  = SELW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SELW-1:0]  first_sel,
  input  logic [SELW-1:0]  len,
  input  logic             abort,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic [SELW-1:0]  sel,
  output logic             busy,
  output logic             done
);

  // One extra bit so len=15 can encode 16 remaining transfers.
  localparam int REMW = SELW + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic [REMW-1:0]  remaining_q, remaining_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    sel_d       = sel_q;
    remaining_d = remaining_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = SEND;
          data_d      = data_in;
          sel_d       = first_sel;
          remaining_d = {1'b0, len} + REMW'(1);
          valid_d     = 1'b1;
          busy_d      = 1'b1;
        end
      end

      SEND: begin
        // Abort wins over a transfer happening in the same cycle.
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (ser_ready) begin
          if (remaining_q == REMW'(1)) begin
            state_d     = DONE;
            remaining_d = '0;
            valid_d     = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else begin
            sel_d       = sel_q + SELW'(1);
            remaining_d = remaining_q - REMW'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      sel_q       <= '0;
      remaining_q <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
      remaining_q <= remaining_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  mux_bit_sel #(
    .WIDTH (WIDTH),
    .SELW  (SELW)
  ) u_bit_sel (
    .data   (data_q),
    .select (sel_q),
    .out    (ser_out)
  );

  assign ser_valid = valid_q;
  assign sel       = sel_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: table of full scans plus hand-written
// stall, abort, restart-ignore and mid-scan reset sequences.
module tb_mux_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] data_in;
  logic [3:0]  first_sel;
  logic [3:0]  len;
  logic        abort;
  logic        ser_ready;
  logic        ser_out;
  logic        ser_valid;
  logic [3:0]  sel;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [15:0] data;
    logic [3:0]  first;
    logic [3:0]  len;
    logic [15:0] exp_bits;
    logic        with_abort;
  } vec_t;

  vec_t vecs[5];

  mux_scan_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .first_sel (first_sel),
    .len       (len),
    .abort     (abort),
    .ser_ready (ser_ready),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .sel       (sel),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkIdle(input string tag, input logic exp_done);
    checkOutput({tag, " valid"}, 32'(ser_valid), 32'(1'b0));
    checkOutput({tag, " busy"}, 32'(busy), 32'(1'b0));
    checkOutput({tag, " done"}, 32'(done), 32'(exp_done));
  endtask

  // Full scan with ser_ready held high; expected bit i is exp_bits[i].
  task automatic applyStimulus(input vec_t v);
    logic [3:0] exp_sel;
    start     = 1'b1;
    abort     = v.with_abort;
    data_in   = v.data;
    first_sel = v.first;
    len       = v.len;
    ser_ready = 1'b1;
    nextCycle();
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i <= int'(v.len); i++) begin
      exp_sel = v.first + 4'(i);
      checkOutput($sformatf("%s valid[%0d]", v.name, i), 32'(ser_valid), 32'(1'b1));
      checkOutput($sformatf("%s busy[%0d]", v.name, i), 32'(busy), 32'(1'b1));
      checkOutput($sformatf("%s sel[%0d]", v.name, i), 32'(sel), 32'(exp_sel));
      checkOutput($sformatf("%s bit[%0d]", v.name, i), 32'(ser_out), 32'(v.exp_bits[i]));
      nextCycle();
    end
    checkIdle({v.name, " done-cycle"}, 1'b1);
    nextCycle();
    checkIdle({v.name, " after-done"}, 1'b0);
  endtask

  initial begin
    logic [15:0] word;
    logic [3:0]  idx;
    logic        ready_pat[8];

    vecs[0] = '{"a5c3_full", 16'hA5C3, 4'd0, 4'd15, 16'hA5C3, 1'b0};
    vecs[1] = '{"wrap14", 16'h8001, 4'd14, 4'd3, 16'h0006, 1'b0};
    vecs[2] = '{"mid6", 16'h00F0, 4'd2, 4'd5, 16'h003C, 1'b0};
    vecs[3] = '{"abort_start", 16'h8001, 4'd15, 4'd1, 16'h0003, 1'b1};
    vecs[4] = '{"single", 16'h0010, 4'd4, 4'd0, 16'h0001, 1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; ser_ready = 1'b0;
    data_in = '0; first_sel = '0; len = '0;
    nextCycle();
    nextCycle();
    checkIdle("reset", 1'b0);
    checkOutput("reset sel", 32'(sel), 32'd0);
    checkOutput("reset ser_out", 32'(ser_out), 32'd0);
    rst = 1'b0;
    nextCycle();

    for (int v = 0; v < 5; v++) applyStimulus(vecs[v]);

    // Stall: ready pattern 1,1,0,0,1,1,1,1 over a 6-bit scan.
    $display("[TB] stall sequence");
    word = 16'hA5C3;
    ready_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    start = 1'b1; data_in = word; first_sel = 4'd0; len = 4'd5; ser_ready = 1'b1;
    nextCycle();
    start = 1'b0;
    idx = 4'd0;
    for (int c = 0; c < 8; c++) begin
      checkOutput($sformatf("stall valid[%0d]", c), 32'(ser_valid), 32'(1'b1));
      checkOutput($sformatf("stall sel[%0d]", c), 32'(sel), 32'(idx));
      checkOutput($sformatf("stall bit[%0d]", c), 32'(ser_out), 32'(word[idx]));
      ser_ready = ready_pat[c];
      if (ready_pat[c]) idx = idx + 4'd1;
      nextCycle();
    end
    checkIdle("stall done-cycle", 1'b1);
    nextCycle();

    // Abort on the third SEND cycle, simultaneous with a ready transfer.
    $display("[TB] abort sequence");
    start = 1'b1; data_in = 16'hFFFF; first_sel = 4'd0; len = 4'd10; ser_ready = 1'b1;
    nextCycle();
    start = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("abort pre sel", 32'(sel), 32'd2);
    abort = 1'b1;
    nextCycle();
    abort = 1'b0;
    checkIdle("abort idle", 1'b0);
    checkOutput("abort sel held", 32'(sel), 32'd2);
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      checkIdle($sformatf("abort quiet[%0d]", c), 1'b0);
    end
    applyStimulus(vecs[2]);

    // Start pulsed in SEND and in DONE must not disturb the running scan.
    $display("[TB] start-ignore sequence");
    word = 16'hA5C3;
    start = 1'b1; data_in = word; first_sel = 4'd0; len = 4'd7; ser_ready = 1'b1;
    nextCycle();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("ignore sel[%0d]", i), 32'(sel), 32'(i));
      checkOutput($sformatf("ignore bit[%0d]", i), 32'(ser_out), 32'(word[i]));
      start = (i == 1);
      data_in = 16'h0000; first_sel = 4'd9; len = 4'd1;
      nextCycle();
    end
    checkIdle("ignore done-cycle", 1'b1);
    start = 1'b1;
    nextCycle();
    start = 1'b0;
    checkIdle("ignore after-done", 1'b0);
    checkOutput("ignore idle sel", 32'(sel), 32'd7);
    checkOutput("ignore idle bit", 32'(ser_out), 32'(word[7]));

    // Reset mid-scan, asserted together with start and abort.
    $display("[TB] reset mid-scan sequence");
    nextCycle();
    start = 1'b1; data_in = 16'hFFFF; first_sel = 4'd3; len = 4'd10; ser_ready = 1'b1;
    nextCycle();
    start = 1'b0;
    nextCycle();
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    nextCycle();
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    checkIdle("midrst", 1'b0);
    checkOutput("midrst sel", 32'(sel), 32'd0);
    checkOutput("midrst ser_out", 32'(ser_out), 32'd0);
    nextCycle();
    checkIdle("midrst quiet", 1'b0);
    applyStimulus(vecs[4]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
